// File: rtl/fan_off_timer_pkg.sv
// Shared definitions for the fan auto-off timer: state encodings, LED one-hot
// constants and output widths. The fan power stage uses the same encodings.
package fan_off_timer_pkg;

    localparam int unsigned REMAIN_W = 10;
    localparam int unsigned LED_W    = 3;

    // Timer states; the numeric value doubles as the preset index.
    typedef enum logic [1:0] {
        TMR_OFF  = 2'd0,
        TMR_ARM1 = 2'd1,
        TMR_ARM2 = 2'd2,
        TMR_ARM3 = 2'd3
    } tmr_state_e;

    localparam logic [LED_W-1:0] LED_OFF = 3'b000;
    localparam logic [LED_W-1:0] LED_T1  = 3'b001;
    localparam logic [LED_W-1:0] LED_T2  = 3'b010;
    localparam logic [LED_W-1:0] LED_T3  = 3'b100;

    // Preset indicator for a given timer state.
    function automatic logic [LED_W-1:0] led_of(input tmr_state_e s);
        logic [LED_W-1:0] led;
        case (s)
            TMR_ARM1: led = LED_T1;
            TMR_ARM2: led = LED_T2;
            TMR_ARM3: led = LED_T3;
            default:  led = LED_OFF;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/fan_off_timer_if.sv
// Timer control/status bundle between the button/motor side and the timer.
//   btn_pe     : debounced button rising-edge pulse (1 cycle)
//   motor_run  : power stage is not IDLE
//   timer_end  : 1-cycle expiry pulse to the power stage
//   led_timer  : one-hot preset indicator
//   remain_sec : seconds remaining, 0 when off
interface fan_off_timer_if;
    import fan_off_timer_pkg::*;

    logic                btn_pe;
    logic                motor_run;
    logic                timer_end;
    logic [LED_W-1:0]    led_timer;
    logic [REMAIN_W-1:0] remain_sec;

    modport master (
        output btn_pe,
        output motor_run,
        input  timer_end,
        input  led_timer,
        input  remain_sec
    );

    modport slave (
        input  btn_pe,
        input  motor_run,
        output timer_end,
        output led_timer,
        output remain_sec
    );

endinterface

// File: rtl/fan_off_timer_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and flags the wrap.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : count enable
//   tick_c       : combinational, high in the last cycle of each second
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned     CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick_c = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fan_off_timer.sv
// Fan auto-off countdown: button cycles OFF->T1->T2->T3->OFF while the motor
// runs, counts down in seconds and pulses timer_end at zero.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : btn_pe, motor_run in; timer_end, led_timer, remain_sec out
module fan_off_timer
    import fan_off_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned T1_SEC = 60,
    parameter int unsigned T2_SEC = 180,
    parameter int unsigned T3_SEC = 300
) (
    input  logic            clk,
    input  logic            reset_n,
    fan_off_timer_if.slave  bus
);

    localparam logic [REMAIN_W-1:0] PRESET1 = REMAIN_W'(T1_SEC);
    localparam logic [REMAIN_W-1:0] PRESET2 = REMAIN_W'(T2_SEC);
    localparam logic [REMAIN_W-1:0] PRESET3 = REMAIN_W'(T3_SEC);

    tmr_state_e          state_q, state_d;
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic [LED_W-1:0]    led_q;
    logic                end_q, end_d;
    logic                load_c;
    logic                tick_c;
    logic                presc_clr_c;
    logic                presc_en_c;

    // The prescaler restarts on every preset load so the first second is full.
    assign presc_en_c  = (state_q != TMR_OFF) && bus.motor_run;
    assign presc_clr_c = load_c || (state_q == TMR_OFF);

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (presc_clr_c),
        .en      (presc_en_c),
        .tick_c  (tick_c)
    );

    // State, countdown and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= TMR_OFF;
            remain_q <= '0;
            led_q    <= LED_OFF;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            led_q    <= led_of(state_d);
            end_q    <= end_d;
        end
    end

    // Next state; priority is motor stop > expiry > button > plain tick.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        end_d    = 1'b0;
        load_c   = 1'b0;
        if (state_q != TMR_OFF) begin
            if (!bus.motor_run) begin
                state_d  = TMR_OFF;
                remain_d = '0;
            end else if (tick_c && (remain_q == REMAIN_W'(1))) begin
                state_d  = TMR_OFF;
                remain_d = '0;
                end_d    = 1'b1;
            end else if (bus.btn_pe) begin
                case (state_q)
                    TMR_ARM1: begin
                        state_d  = TMR_ARM2;
                        remain_d = PRESET2;
                        load_c   = 1'b1;
                    end
                    TMR_ARM2: begin
                        state_d  = TMR_ARM3;
                        remain_d = PRESET3;
                        load_c   = 1'b1;
                    end
                    default: begin
                        state_d  = TMR_OFF;
                        remain_d = '0;
                    end
                endcase
            end else if (tick_c && (remain_q != '0)) begin
                remain_d = remain_q - REMAIN_W'(1);
            end
        end else if (bus.btn_pe && bus.motor_run) begin
            state_d  = TMR_ARM1;
            remain_d = PRESET1;
            load_c   = 1'b1;
        end
    end

    assign bus.timer_end  = end_q;
    assign bus.led_timer  = led_q;
    assign bus.remain_sec = remain_q;

endmodule
